// File: rtl/image_three2window.sv
// 3x3 window assembler: reads one padded row-triple column by column from the line buffer and streams windows.
// Optional stride-2 emission is enabled by defining IMAGE_WINDOW_STRIDE2_EN.
`ifndef IMAGE_WIDTH_DATA
`define IMAGE_WIDTH_DATA 8
`endif

module image_three2window #(
    parameter int WIDTH     = `IMAGE_WIDTH_DATA,
    parameter int RD_LAT    = 2,
    parameter int RET_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               Start_Row,
    input  logic [9:0]         Row_Num_After_Padding,
`ifdef IMAGE_WINDOW_STRIDE2_EN
    input  logic               Stride,
`endif
    output logic [9:0]         S_Addr,
    input  logic [3*WIDTH-1:0] S_Data,
    output logic               Busy,
    output logic [9*WIDTH-1:0] M_Data,
    output logic               M_Valid,
    input  logic               M_Ready,
    output logic               M_Last
);

    localparam int CW = $clog2(RET_DEPTH + 1);
    localparam int PW = $clog2(RET_DEPTH);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t               state_q, state_d;
    logic [9:0]           n_q, rd_cnt_q, pop_cnt_q, s_addr_q;
    logic                 stride_q;
    logic [RD_LAT-1:0]    dly_q;
    logic [3*WIDTH-1:0]   fifo_q [RET_DEPTH];
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        cnt_q;
    logic [1:0]           cols_q;
    logic [3*WIDTH-1:0]   c0_q, c1_q;
    logic [9*WIDTH-1:0]   m_data_q;
    logic                 m_valid_q, m_last_q, last_acc_q;

    logic [7:0]           occ;
    logic                 issue, push, pop, emit, accept, done;
    logic [3*WIDTH-1:0]   head;
    logic [9*WIDTH-1:0]   window;
    logic [9:0]           last_col;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RET_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credit counts reads still in the delay line plus entries already queued.
    always_comb begin
        occ = 8'(cnt_q);
        for (int i = 0; i < RD_LAT; i++) occ = occ + 8'(dly_q[i]);
    end

    always_comb begin
        issue    = (state_q == READ) && (n_q >= 10'd3) && (occ < 8'(RET_DEPTH));
        push     = dly_q[RD_LAT-1];
        head     = fifo_q[rd_ptr_q];
        pop      = (cnt_q != '0) && ((cols_q != 2'd2) || !m_valid_q || M_Ready);
        emit     = pop && (cols_q == 2'd2) && (!stride_q || !pop_cnt_q[0]);
        last_col = stride_q ? ((n_q - 10'd1) & ~10'd1) : (n_q - 10'd1);
        accept   = m_valid_q && M_Ready;
        done     = (state_q == DRAIN) && (pop_cnt_q == n_q) &&
                   (last_acc_q || (accept && m_last_q));
        window   = '0;
        for (int r = 0; r < 3; r++) begin
            window[(r*3+0)*WIDTH +: WIDTH] = c0_q[r*WIDTH +: WIDTH];
            window[(r*3+1)*WIDTH +: WIDTH] = c1_q[r*WIDTH +: WIDTH];
            window[(r*3+2)*WIDTH +: WIDTH] = head[r*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (Start_Row) state_d = READ;
            READ: begin
                if (n_q < 10'd3)                             state_d = IDLE;
                else if (issue && (rd_cnt_q == n_q - 10'd1)) state_d = DRAIN;
            end
            DRAIN: if (done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            n_q        <= '0;
            rd_cnt_q   <= '0;
            pop_cnt_q  <= '0;
            s_addr_q   <= '0;
            stride_q   <= 1'b0;
            dly_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            cols_q     <= '0;
            c0_q       <= '0;
            c1_q       <= '0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            last_acc_q <= 1'b0;
            for (int i = 0; i < RET_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            if ((state_q == IDLE) && Start_Row) begin
                n_q        <= Row_Num_After_Padding;
                rd_cnt_q   <= '0;
                pop_cnt_q  <= '0;
                last_acc_q <= 1'b0;
`ifdef IMAGE_WINDOW_STRIDE2_EN
                stride_q   <= Stride;
`else
                stride_q   <= 1'b0;
`endif
            end

            if (issue) begin
                s_addr_q <= rd_cnt_q;
                rd_cnt_q <= rd_cnt_q + 10'd1;
            end

            dly_q[0] <= issue;
            for (int i = 1; i < RD_LAT; i++) dly_q[i] <= dly_q[i-1];

            if (push) begin
                fifo_q[wr_ptr_q] <= S_Data;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end

            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase

            if (pop) begin
                rd_ptr_q  <= ptr_inc(rd_ptr_q);
                c0_q      <= c1_q;
                c1_q      <= head;
                pop_cnt_q <= pop_cnt_q + 10'd1;
                if (cols_q != 2'd2) cols_q <= cols_q + 2'd1;
            end

            // Output slot holds its contents until the downstream takes it.
            if (emit) begin
                m_data_q  <= window;
                m_valid_q <= 1'b1;
                m_last_q  <= (pop_cnt_q == last_col);
            end else if (accept) begin
                m_valid_q <= 1'b0;
                m_last_q  <= 1'b0;
            end

            if (accept && m_last_q) last_acc_q <= 1'b1;

            if (done) begin
                cols_q <= '0;
                c0_q   <= '0;
                c1_q   <= '0;
            end
        end
    end

    assign S_Addr  = issue ? rd_cnt_q : s_addr_q;
    assign Busy    = (state_q != IDLE);
    assign M_Data  = m_data_q;
    assign M_Valid = m_valid_q;
    assign M_Last  = m_last_q;

endmodule

// File: tb/tb_image_three2window.sv
// Bench for image_three2window: line-buffer read model, window scoreboard and a table of row scenarios.
module tb_image_three2window;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst, Start_Row, M_Ready;
    logic [9:0]     Row_Num_After_Padding;
    logic [9:0]     S_Addr;
    logic [3*W-1:0] S_Data, rd1;
    logic           Busy, M_Valid, M_Last;
    logic [9*W-1:0] M_Data;
`ifdef IMAGE_WINDOW_STRIDE2_EN
    logic           Stride;
`endif

    always #5 clk = ~clk;

    image_three2window #(.WIDTH(W), .RD_LAT(2), .RET_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .Start_Row(Start_Row),
        .Row_Num_After_Padding(Row_Num_After_Padding),
`ifdef IMAGE_WINDOW_STRIDE2_EN
        .Stride(Stride),
`endif
        .S_Addr(S_Addr), .S_Data(S_Data), .Busy(Busy),
        .M_Data(M_Data), .M_Valid(M_Valid), .M_Ready(M_Ready), .M_Last(M_Last)
    );

    int tag = 0;

    function automatic logic [W-1:0] pix(input int t, input int r, input int c);
        return W'((t % 4) * 64 + r * 16 + (c % 16));
    endfunction

    function automatic logic [3*W-1:0] col_word(input int t, input int c);
        logic [3*W-1:0] w;
        for (int r = 0; r < 3; r++) w[r*W +: W] = pix(t, r, c);
        return w;
    endfunction

    // Line buffer: address sampled on one edge, data out of the output register on the next.
    always @(posedge clk) begin
        rd1    <= col_word(tag, int'(S_Addr));
        S_Data <= rd1;
    end

    typedef struct {
        logic [9*W-1:0] data;
        logic           last;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        int n;
        bit st;
        int mode;
        int exp_win;
        bit chk_lat;
    } vec_t;
    vec_t tbl[$];

    int checks = 0, errors = 0, cyc = 0;
    int win_cnt, first_vld;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic tick();
        logic pv, pr, pl, prst;
        logic [9*W-1:0] pd;
        exp_t e;
        pv = M_Valid; pr = M_Ready; pd = M_Data; pl = M_Last; prst = rst;
        @(posedge clk);
        #1;
        cyc++;
        if (pv === 1'b1 && pr === 1'b1 && prst === 1'b1) begin
            win_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_window", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("win_data", pd, e.data);
                chk("win_last", pl, e.last);
            end
            if (pl) chk("busy_after_last", Busy, 0);
        end
        if (pv === 1'b1 && pr === 1'b0 && prst === 1'b1) begin
            chk("stall_valid", M_Valid, 1);
            chk("stall_data", M_Data, pd);
            chk("stall_last", M_Last, pl);
        end
        if (M_Valid === 1'b1 && first_vld < 0) first_vld = cyc;
    endtask

    function automatic logic rdy(input int mode, input int k);
        if (mode == 1) return (k % 3 == 0);
        if (mode == 2) return 1'($urandom_range(0, 1));
        return 1'b1;
    endfunction

    task automatic build_exp(input int n, input bit st);
        int last_c2;
        exp_t e;
        last_c2 = -1;
        for (int c2 = 2; c2 < n; c2++) if (!(st && (c2 % 2 == 1))) last_c2 = c2;
        for (int c2 = 2; c2 < n; c2++) begin
            if (st && (c2 % 2 == 1)) continue;
            for (int r = 0; r < 3; r++)
                for (int k = 0; k < 3; k++)
                    e.data[(r*3+k)*W +: W] = pix(tag, r, c2 - 2 + k);
            e.last = (c2 == last_c2);
            exp_q.push_back(e);
        end
    endtask

    task automatic start_row(input int n, input bit st);
        Row_Num_After_Padding = 10'(n);
`ifdef IMAGE_WINDOW_STRIDE2_EN
        Stride = st;
`endif
        Start_Row = 1'b1;
        M_Ready = 1'b1;
        win_cnt = 0;
        first_vld = -1;
        tick();
        Start_Row = 1'b0;
    endtask

    task automatic run_row(input vec_t v);
        int start, k, busy_cyc;
        logic [9:0] sa0;
        bit sa_changed;
        build_exp(v.n, v.st);
        sa0 = S_Addr;
        sa_changed = 0;
        start_row(v.n, v.st);
        start = cyc;
        chk("busy_start", Busy, 1);
        busy_cyc = 0;
        k = 1;
        while (Busy === 1'b1 && k < 400) begin
            busy_cyc++;
            if (S_Addr !== sa0) sa_changed = 1;
            M_Ready = rdy(v.mode, k);
            // A second pulse mid-row must be ignored.
            Start_Row = (v.mode == 1 && k == 5);
            if (Start_Row) Row_Num_After_Padding = 10'd3;
            k++;
            tick();
            Start_Row = 1'b0;
        end
        chk("busy_timeout", (k < 400), 1);
        chk("win_count", win_cnt, v.exp_win);
        chk("queue_empty", exp_q.size(), 0);
        if (v.chk_lat) chk("first_latency", first_vld - start, 6);
        if (v.n < 3) begin
            chk("short_busy_cycles", busy_cyc, 1);
            chk("short_no_reads", sa_changed, 0);
            chk("short_no_valid", first_vld, -1);
        end
        exp_q.delete();
        tag++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; Start_Row = 1'b0; M_Ready = 1'b0; Row_Num_After_Padding = '0;
`ifdef IMAGE_WINDOW_STRIDE2_EN
        Stride = 1'b0;
`endif
        win_cnt = 0; first_vld = -1;
        repeat (3) tick();
        chk("rst_saddr", S_Addr, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_valid", M_Valid, 0);
        chk("rst_last", M_Last, 0);
        chk("rst_data", M_Data, 0);
        rst = 1'b1;
        tick();

        tbl.push_back('{n: 8, st: 0, mode: 0, exp_win: 6, chk_lat: 1});
        tbl.push_back('{n: 8, st: 0, mode: 1, exp_win: 6, chk_lat: 0});
        tbl.push_back('{n: 2, st: 0, mode: 0, exp_win: 0, chk_lat: 0});
        tbl.push_back('{n: 5, st: 0, mode: 0, exp_win: 3, chk_lat: 1});
        tbl.push_back('{n: 5, st: 0, mode: 2, exp_win: 3, chk_lat: 0});
        tbl.push_back('{n: 5, st: 0, mode: 0, exp_win: 3, chk_lat: 1});
        tbl.push_back('{n: 3, st: 0, mode: 0, exp_win: 1, chk_lat: 1});
`ifdef IMAGE_WINDOW_STRIDE2_EN
        tbl.push_back('{n: 9, st: 1, mode: 0, exp_win: 4, chk_lat: 1});
        tbl.push_back('{n: 8, st: 1, mode: 1, exp_win: 3, chk_lat: 0});
`endif
        foreach (tbl[i]) run_row(tbl[i]);

        // Reset in the middle of an N=10 row after two windows.
        begin
            int k;
            build_exp(10, 1'b0);
            start_row(10, 1'b0);
            k = 0;
            while (win_cnt < 2 && k < 100) begin
                M_Ready = 1'b1;
                k++;
                tick();
            end
            chk("midrow_two_windows", win_cnt, 2);
            rst = 1'b0;
            M_Ready = 1'b0;
            tick();
            chk("midrst_busy", Busy, 0);
            chk("midrst_valid", M_Valid, 0);
            chk("midrst_last", M_Last, 0);
            chk("midrst_data", M_Data, 0);
            rst = 1'b1;
            exp_q.delete();
            tag++;
            tick();
            chk("midrst_idle_valid", M_Valid, 0);
            run_row('{n: 10, st: 0, mode: 0, exp_win: 8, chk_lat: 1});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
